// File: rtl/cgol_engine.sv
// Row-serial Conway's Game of Life engine: seed load, single-step and timed free-run.
// Optional period-2 oscillator detection is enabled by defining CGOL_OSC2_DETECT_EN.
module cgol_engine #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned GEN_W      = 16,
    parameter int unsigned RUN_PERIOD = 12_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS*COLS-1:0] i_seed,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic                 i_run,
    input  logic                 i_wrap,
    output logic [ROWS*COLS-1:0] o_board,
    output logic [GEN_W-1:0]     o_generation,
    output logic                 o_busy,
    output logic                 o_done,
`ifdef CGOL_OSC2_DETECT_EN
    output logic                 o_osc2,
`endif
    output logic                 o_stable
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned TW = $clog2(RUN_PERIOD);

    typedef enum logic [1:0] {StIdle, StCompute, StCommit} state_e;

    state_e                     state_q, state_d;
    logic [ROWS-1:0][COLS-1:0]  board_q, board_d, next_q, next_d;
    logic [GEN_W-1:0]           gen_q, gen_d;
    logic [RW-1:0]              row_q, row_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic                       wrap_q, wrap_d;
    logic                       stable_q, stable_d;
    logic                       done_q, done_d;
    logic                       run_tick;
    logic [COLS-1:0]            row_new;
`ifdef CGOL_OSC2_DETECT_EN
    logic [ROWS-1:0][COLS-1:0]  prev2_q, prev2_d;
    logic                       osc2_q, osc2_d;
`endif

    // Next-generation value of the row currently selected by row_q.
    always_comb begin : rule
        int         rr;
        int         cc;
        logic [3:0] cnt;
        logic       vis;
        rr      = 0;
        cc      = 0;
        cnt     = '0;
        vis     = 1'b0;
        row_new = '0;
        for (int c = 0; c < COLS; c++) begin
            cnt = '0;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    rr  = int'(row_q) + dr;
                    cc  = c + dc;
                    vis = 1'b1;
                    if (rr < 0) begin
                        rr  = rr + int'(ROWS);
                        vis = wrap_q;
                    end else if (rr >= int'(ROWS)) begin
                        rr  = rr - int'(ROWS);
                        vis = wrap_q;
                    end
                    if (cc < 0) begin
                        cc  = cc + int'(COLS);
                        vis = vis & wrap_q;
                    end else if (cc >= int'(COLS)) begin
                        cc  = cc - int'(COLS);
                        vis = vis & wrap_q;
                    end
                    if (!(dr == 0 && dc == 0) && vis) begin
                        cnt = cnt + {3'b000, board_q[RW'(rr)][CW'(cc)]};
                    end
                end
            end
            row_new[CW'(c)] = (cnt == 4'd3) | (board_q[row_q][CW'(c)] & (cnt == 4'd2));
        end
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        next_d   = next_q;
        gen_d    = gen_q;
        row_d    = row_q;
        wrap_d   = wrap_q;
        stable_d = stable_q;
        done_d   = 1'b0;
        timer_d  = '0;
        run_tick = 1'b0;
`ifdef CGOL_OSC2_DETECT_EN
        prev2_d  = prev2_q;
        osc2_d   = osc2_q;
`endif
        // The run timer free-runs regardless of busy; its tick is dropped unless idle.
        if (i_run) begin
            if (timer_q == TW'(RUN_PERIOD - 1)) begin
                run_tick = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (i_step || run_tick) begin
                    wrap_d  = i_wrap;
                    row_d   = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                next_d[row_q] = row_new;
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = StCommit;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            StCommit: begin
                board_d  = next_q;
                gen_d    = gen_q + GEN_W'(1);
                stable_d = (next_q == board_q);
                done_d   = 1'b1;
                state_d  = StIdle;
`ifdef CGOL_OSC2_DETECT_EN
                osc2_d   = (next_q == prev2_q) & (next_q != board_q);
                prev2_d  = board_q;
`endif
            end
            default: state_d = StIdle;
        endcase

        // Load overrides everything, including an in-flight generation.
        if (i_load) begin
            board_d  = i_seed;
            gen_d    = '0;
            stable_d = 1'b0;
            done_d   = 1'b0;
            state_d  = StIdle;
`ifdef CGOL_OSC2_DETECT_EN
            prev2_d  = '0;
            osc2_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            board_q  <= '0;
            next_q   <= '0;
            gen_q    <= '0;
            row_q    <= '0;
            timer_q  <= '0;
            wrap_q   <= 1'b0;
            stable_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef CGOL_OSC2_DETECT_EN
            prev2_q  <= '0;
            osc2_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            next_q   <= next_d;
            gen_q    <= gen_d;
            row_q    <= row_d;
            timer_q  <= timer_d;
            wrap_q   <= wrap_d;
            stable_q <= stable_d;
            done_q   <= done_d;
`ifdef CGOL_OSC2_DETECT_EN
            prev2_q  <= prev2_d;
            osc2_q   <= osc2_d;
`endif
        end
    end

    assign o_board      = board_q;
    assign o_generation = gen_q;
    assign o_busy       = (state_q != StIdle);
    assign o_done       = done_q;
    assign o_stable     = stable_q;
`ifdef CGOL_OSC2_DETECT_EN
    assign o_osc2       = osc2_q;
`endif

endmodule

// File: doc/cgol_engine.md
Name: cgol_engine

Overview:
Parametrised Conway's Game of Life core for a ROWS x COLS board. It replaces the fixed 8x8 single-shot combinational evaluation with a row-serial generation engine. The engine has seed load, single-step and free-run control, a selectable boundary mode, a generation counter and a stable-board flag. It sits between the seed ROM and the WS2812B frame driver; the frame driver reads o_board after each o_done pulse.

Parameters:
ROWS, 8, board height (>=3)
COLS, 8, board width (>=3)
GEN_W, 16, generation counter width
RUN_PERIOD, 12_000_000, clk cycles between auto-steps in run mode (>= ROWS+2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_seed  in  ROWS*COLS  seed board; cell (r,c) at bit r*COLS+c
i_load  in  1  pulse: copy i_seed into board
i_step  in  1  pulse: compute one generation
i_run  in  1  level: auto-step every RUN_PERIOD cycles
i_wrap  in  1  1 = cyclic (toroidal) boundary, 0 = cells outside the board are dead
o_board  out  ROWS*COLS  current generation, same bit mapping as i_seed
o_generation  out  GEN_W  generations computed since last load
o_busy  out  1  high in COMPUTE/COMMIT
o_done  out  1  one-cycle pulse when o_board updates
o_stable  out  1  last committed generation equal to its predecessor

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - board = 0, next buffer = 0, generation = 0
  - o_busy = 0, o_done = 0, o_stable = 0
  - run timer = 0, state = IDLE
- FSM states: IDLE, COMPUTE, COMMIT.
- IDLE:
  - i_load high -> board <= i_seed, generation <= 0, o_stable <= 0; stay IDLE.
  - Else step request (i_step, or a run tick) -> latch i_wrap into wrap_q, row <= 0, go to COMPUTE.
  - i_load and a step request in the same cycle -> load wins; step dropped.
- COMPUTE, one row per cycle:
  - next[row] <= rule(board, row, wrap_q).
  - row == ROWS-1 -> go to COMMIT; otherwise row++.
  - board is not modified during COMPUTE.
- COMMIT, one cycle:
  - board <= next, generation <= generation+1 (wraps modulo 2^GEN_W).
  - o_stable <= (next == board), o_done pulses for 1 cycle.
  - Return to IDLE.
- Latency: step accepted at edge k -> o_board updates and o_done is high at edge k+ROWS+1. o_busy is high over edges k+1..k+ROWS+1.
- Rule, per cell:
  - n = count of 8 neighbours, 4-bit, range 0..8.
  - alive' = (alive & (n==2 | n==3)) | (~alive & n==3).
- Neighbour indexing:
  - wrap_q=1: rows and cols taken modulo ROWS/COLS.
  - wrap_q=0: out-of-range neighbours read as 0.
- i_step or run tick while busy: ignored, not queued.
- i_load while busy: aborts the generation. board <= i_seed, generation <= 0, o_stable <= 0, no o_done, state -> IDLE the next cycle.
- i_wrap changes mid-generation have no effect until the next accept.
- Run timer:
  - Counts while i_run=1; cleared to 0 while i_run=0.
  - At RUN_PERIOD-1 it wraps to 0 and raises a one-cycle internal step request.
  - Timer keeps counting while busy.
- o_board is a registered copy of board; no glitches mid-COMPUTE.

Optional Feature:
CGOL_OSC2_DETECT_EN
- Defined:
  - Adds a prev2 register (ROWS*COLS bits, reset 0) and output o_osc2 (1 bit, reset 0).
  - At COMMIT: o_osc2 <= (next == prev2) & ~(next == board), then prev2 <= board.
  - Load clears prev2 and o_osc2.
  - Flags period-2 oscillators such as the blinker and toad.
- Undefined: no prev2 register, no o_osc2 port; all other behaviour identical.

Test Plan:
- Cyclic blinker: default params, load 0x1C000000, i_wrap=1, pulse i_step -> o_done at edge k+9, o_board=0x0000000808080000, o_generation=1, o_stable=0. Second step -> 0x1C000000, generation=2.
- Edge boundary: load 0x7, i_wrap=0, step -> o_board=0x202. Reload 0x7, i_wrap=1, step -> o_board=0x0200000000000202.
- Still life: load block 0x303, step -> o_board=0x303, o_stable=1, generation=1.
- Load abort: step accepted, assert i_load with i_seed=0xFF at 3rd COMPUTE cycle -> no o_done. Next cycle: o_board=0xFF, generation=0, o_busy=0.
- Run mode: RUN_PERIOD=16, i_run=1 from reset-release -> o_done every 16 cycles. i_step asserted while o_busy -> no extra generation. i_run=0 -> no further o_done.
- With CGOL_OSC2_DETECT_EN: blinker as in the first scenario -> o_osc2=0 after gen 1, 1 after gen 2 and every generation after. Block 0x303 -> o_osc2 stays 0.
